down_counter: RTL
=================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, setting the counter and load-data width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1 bit: load din into the counter and reload register, and start a run.
REQ-005 SHALL have port din, input, WIDTH bits: load value, which sets the period in cycles.
REQ-006 SHALL have port en, input, 1 bit: decrement enable.
REQ-007 SHALL have port auto_reload, input, 1 bit: 1 = periodic mode, 0 = one-shot mode; sampled on each decrement.
REQ-008 SHALL have port count, output, WIDTH bits: current counter value, registered.
REQ-009 SHALL have port tc, output, 1 bit: terminal-count pulse, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while state is RUN.
REQ-011 SHALL have port done, output, 1 bit: high while state is DONE.

Function
REQ-012 SHALL implement three states: IDLE, RUN and DONE. busy and done SHALL be decoded directly from the state register.
REQ-013 Event priority on each edge SHALL be rst, then load, then en.
REQ-014 load=1 with din!=0, in any state: count<=din, reload<=din, next state RUN, tc<=0.
REQ-015 load=1 with din==0, in any state: count<=0, reload<=0, next state IDLE, tc<=0, with no terminal-count event.
REQ-016 In RUN with en=1 and count>1: count<=count-1, tc<=0.
REQ-017 In RUN with en=1, count==1 and auto_reload=0: count<=0, tc<=1, next state DONE.
REQ-018 In RUN with en=1, count==1 and auto_reload=1: count<=reload, tc<=1, state stays RUN.
REQ-019 Together, REQ-016 to REQ-018 SHALL give a period of exactly din enabled cycles between tc pulses.
REQ-020 In RUN with en=0: count and state SHALL hold, and tc<=0.
REQ-021 In IDLE or DONE: en SHALL be ignored, count SHALL hold (0 in DONE), and tc<=0.
REQ-022 tc SHALL be high for exactly one cycle per terminal-count event. It SHALL be high in the same cycle that count first shows 0 (one-shot) or the reloaded value (periodic).
REQ-023 count SHALL never wrap from 0 to all-ones. No decrement SHALL occur outside RUN.
REQ-024 A load in RUN while count==1 and en=1 SHALL take precedence: count<=din, no tc pulse.
REQ-025 Changing auto_reload mid-run SHALL take effect at the next count==1 decrement. No other side effect SHALL occur.
REQ-026 din SHALL be sampled only on edges where load=1.
REQ-027 Arithmetic SHALL be unsigned, modulo 2^WIDTH. The maximum period SHALL be 2^WIDTH-1 cycles.

Reset
REQ-028 rst=1 on an edge SHALL set count=0, reload=0, tc=0, state IDLE (busy=0, done=0).
REQ-029 rst SHALL override load and en on the same edge.
REQ-030 Reset SHALL be honoured in any state, including mid-run; no tc SHALL be produced by a reset.

Verification
REQ-031 rst=1 with load=1, din=4'b1010 on the same edge -> count=0, tc=0, busy=0, done=0.
REQ-032 One-shot: load with din=4'b1010, then en=1, auto_reload=0 -> count 10,9,...,1,0. tc=1 only in the cycle count=0; then done=1, busy=0. Further en keeps count=0 with tc=0.
REQ-033 Periodic: load with din=3, then en=1, auto_reload=1 -> count 3,2,1,3,2,1,... with tc=1 on each reload cycle (every 3 cycles); busy stays 1.
REQ-034 Pause: run from din=5 with en=1 for 2 cycles, en=0 for 3 cycles, then en=1 -> count 5,4,3,3,3,3,2,...; no tc during the pause.
REQ-035 Restart at the boundary: with count==1 and en=1, assert load with din=7 -> count=7, tc=0, busy=1. Separately, load with din=0 -> count=0, state IDLE, tc=0.
REQ-036 Mid-run reset: rst=1 while count=6 in RUN -> next cycle count=0, busy=0, done=0, tc=0. A subsequent en=1 with no load leaves count at 0.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down counter with a terminal-count pulse and one-shot or periodic reload.
// The state register drives busy and done directly.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        // NOTE: every _d gets a default first, so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = din;
            reload_d = din;
            state_d  = (din != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop updates from its value before the edge.
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule
